// File: rtl/multibyte_add_seq_pkg.sv
// Shared encodings for the multibyte add/sub sequencer: FSM states and byte width.
package multibyte_add_seq_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/multibyte_add_seq_if.sv
// Request/result bundle between the ALU control path (master) and the sequencer (slave).
interface multibyte_add_seq_if
  import multibyte_add_seq_pkg::*;
#(
  parameter int NBYTES = 4
);
  logic                       start;
  logic                       sub;
  logic [BYTE_W*NBYTES-1:0]   a;
  logic [BYTE_W*NBYTES-1:0]   b;
  logic                       busy;
  logic                       done;
  logic [BYTE_W*NBYTES-1:0]   sum;
  logic                       cout;
  logic                       ovf;

  modport master (
    output start, sub, a, b,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/multibyte_add_seq_byte_adder.sv
// Shared 8-bit adder with carry in/out; purely combinational, reused for every byte.
module multibyte_add_seq_byte_adder
  import multibyte_add_seq_pkg::*;
(
  input  logic [BYTE_W-1:0] a_i,
  input  logic [BYTE_W-1:0] b_i,
  input  logic              c_i,
  output logic [BYTE_W-1:0] o_o,
  output logic              co_o
);

  assign {co_o, o_o} = {1'b0, a_i} + {1'b0, b_i} + {{BYTE_W{1'b0}}, c_i};

endmodule

// File: rtl/multibyte_add_seq.sv
// Byte-serial add/sub of two NBYTES operands through one shared byte adder, LSB first.
// Start accepted in IDLE or DONE; done pulses NBYTES+1 cycles later; start during RUN is dropped.
module multibyte_add_seq
  import multibyte_add_seq_pkg::*;
#(
  parameter int NBYTES = 4
)(
  input  logic                clk,
  input  logic                rst,
  multibyte_add_seq_if.slave  bus_if
);

  localparam int W  = BYTE_W * NBYTES;
  localparam int CW = $clog2(NBYTES + 1);
  localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   idx_q, idx_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            carry_q, carry_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;

  logic [BYTE_W-1:0] add_o;
  logic              add_co;
  logic              c_msb;

  multibyte_add_seq_byte_adder u_byte_adder (
    .a_i  (a_q[BYTE_W-1:0]),
    .b_i  (b_q[BYTE_W-1:0]),
    .c_i  (carry_q),
    .o_o  (add_o),
    .co_o (add_co)
  );

  // Carry into bit 7 recovered from the sum bit, so the adder needs no extra port.
  assign c_msb = a_q[BYTE_W-1] ^ b_q[BYTE_W-1] ^ add_o[BYTE_W-1];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (bus_if.start) begin
          a_d     = bus_if.a;
          b_d     = bus_if.sub ? ~bus_if.b : bus_if.b;
          carry_d = bus_if.sub;
          idx_d   = '0;
          sum_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        for (int i = 0; i < NBYTES; i++) begin
          if (idx_q == CW'(i)) sum_d[i*BYTE_W +: BYTE_W] = add_o;
        end
        carry_d = add_co;
        idx_d   = idx_q + CW'(1);
        a_d     = a_q >> BYTE_W;
        b_d     = b_q >> BYTE_W;
        if (idx_q == LAST) begin
          cout_d  = add_co;
          ovf_d   = c_msb ^ add_co;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus_if.busy = (state_q == ST_RUN);
  assign bus_if.done = (state_q == ST_DONE);
  assign bus_if.sum  = sum_q;
  assign bus_if.cout = cout_q;
  assign bus_if.ovf  = ovf_q;

endmodule
